// File: rtl/rob_multi_commit.sv
// Reorder buffer: two writeback ports, up to COMMIT_W in-order commits per cycle, flush on mispredict.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle writebacks onto the operand query ports.
module rob_multi_commit #(
  parameter int DEPTH    = 16,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int COMMIT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             rdy_i,
  input  logic             disp_valid_i,
  input  logic [31:0]      disp_pc_i,
  input  logic [4:0]       disp_rd_i,
  input  logic             disp_is_br_i,
  input  logic             disp_pred_taken_i,
  input  logic             disp_is_store_i,
  output logic [TAG_W-1:0] disp_tag_o,
  output logic             rob_full_o,
  input  logic             wb0_valid_i,
  input  logic [TAG_W-1:0] wb0_tag_i,
  input  logic [31:0]      wb0_res_i,
  input  logic             wb1_valid_i,
  input  logic [TAG_W-1:0] wb1_tag_i,
  input  logic [31:0]      wb1_res_i,
  input  logic             wb1_taken_i,
  input  logic [31:0]      wb1_target_i,
  input  logic [TAG_W-1:0] q0_tag_i,
  input  logic [TAG_W-1:0] q1_tag_i,
  output logic             q0_ready_o,
  output logic             q1_ready_o,
  output logic [31:0]      q0_value_o,
  output logic [31:0]      q1_value_o,
  output logic [TAG_W-1:0] head_tag_o,
  output logic             head_is_store_o,
  output logic             commit0_valid_o,
  output logic [4:0]       commit0_rd_o,
  output logic [31:0]      commit0_res_o,
  output logic [TAG_W-1:0] commit0_tag_o,
  output logic             commit1_valid_o,
  output logic [4:0]       commit1_rd_o,
  output logic [31:0]      commit1_res_o,
  output logic [TAG_W-1:0] commit1_tag_o,
  output logic             flush_o,
  output logic [31:0]      flush_pc_o,
  output logic             bp_upd_valid_o,
  output logic [31:0]      bp_upd_pc_o,
  output logic             bp_upd_taken_o
);
  localparam int CNT_W = TAG_W + 1;

  logic [TAG_W-1:0] head_q, tail_q, head_d, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q  [DEPTH];
  logic [31:0]      res_q    [DEPTH];
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic             is_br_q  [DEPTH];
  logic             pred_q   [DEPTH];
  logic             taken_q  [DEPTH];
  logic             is_st_q  [DEPTH];

  logic             c0_s, c1_s, br_s, mispred_s, disp_acc_s;
  logic [TAG_W-1:0] h1_s, br_tag_s;
  logic [31:0]      flush_pc_s;

  logic             c0_valid_q, c1_valid_q, flush_q, bp_valid_q, bp_taken_q;
  logic [4:0]       c0_rd_q, c1_rd_q;
  logic [31:0]      c0_res_q, c1_res_q, flush_pc_q, bp_pc_q;
  logic [TAG_W-1:0] c0_tag_q, c1_tag_q;

  assign disp_tag_o      = tail_q;
  assign rob_full_o      = (count_q == CNT_W'(DEPTH));
  assign head_tag_o      = head_q;
  assign head_is_store_o = (count_q != {CNT_W{1'b0}}) && is_st_q[head_q];
  assign commit0_valid_o = c0_valid_q;
  assign commit0_rd_o    = c0_rd_q;
  assign commit0_res_o   = c0_res_q;
  assign commit0_tag_o   = c0_tag_q;
  assign commit1_valid_o = c1_valid_q;
  assign commit1_rd_o    = c1_rd_q;
  assign commit1_res_o   = c1_res_q;
  assign commit1_tag_o   = c1_tag_q;
  assign flush_o         = flush_q;
  assign flush_pc_o      = flush_pc_q;
  assign bp_upd_valid_o  = bp_valid_q;
  assign bp_upd_pc_o     = bp_pc_q;
  assign bp_upd_taken_o  = bp_taken_q;

  // Commit selection, branch resolution and pointer next-state.
  always_comb begin
    h1_s = head_q + TAG_W'(1);
    c0_s = (count_q != {CNT_W{1'b0}}) && ready_q[head_q];
    if (COMMIT_W == 2) begin
      c1_s = c0_s && (count_q >= CNT_W'(2)) && ready_q[h1_s] &&
             !is_br_q[head_q] && !is_st_q[head_q] && !is_st_q[h1_s];
    end else begin
      c1_s = 1'b0;
    end
    // A branch in slot 0 blocks slot 1, so at most one branch resolves per cycle.
    if (c0_s && is_br_q[head_q]) begin
      br_s     = 1'b1;
      br_tag_s = head_q;
    end else if (c1_s && is_br_q[h1_s]) begin
      br_s     = 1'b1;
      br_tag_s = h1_s;
    end else begin
      br_s     = 1'b0;
      br_tag_s = head_q;
    end
    mispred_s  = br_s && (taken_q[br_tag_s] != pred_q[br_tag_s]);
    flush_pc_s = taken_q[br_tag_s] ? target_q[br_tag_s] : (pc_q[br_tag_s] + 32'd4);
    disp_acc_s = disp_valid_i && !rob_full_o && !flush_q;
    if (mispred_s) begin
      head_d  = {TAG_W{1'b0}};
      tail_d  = {TAG_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      head_d  = head_q + TAG_W'(c0_s) + TAG_W'(c1_s);
      tail_d  = tail_q + TAG_W'(disp_acc_s);
      count_d = count_q + CNT_W'(disp_acc_s) - CNT_W'(c0_s) - CNT_W'(c1_s);
    end
  end

  // Pointers, ready/result storage and registered commit/flush/predictor outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q     <= {TAG_W{1'b0}};
      tail_q     <= {TAG_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        ready_q[i] <= 1'b0;
        res_q[i]   <= 32'd0;
      end
      c0_valid_q <= 1'b0;  c0_rd_q <= 5'd0;  c0_res_q <= 32'd0;  c0_tag_q <= {TAG_W{1'b0}};
      c1_valid_q <= 1'b0;  c1_rd_q <= 5'd0;  c1_res_q <= 32'd0;  c1_tag_q <= {TAG_W{1'b0}};
      flush_q    <= 1'b0;  flush_pc_q <= 32'd0;
      bp_valid_q <= 1'b0;  bp_pc_q <= 32'd0;  bp_taken_q <= 1'b0;
    end else if (rdy_i) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (mispred_s) begin
        for (int i = 0; i < DEPTH; i++) begin
          ready_q[i] <= 1'b0;
          res_q[i]   <= 32'd0;
        end
      end else begin
        if (disp_acc_s) ready_q[tail_q] <= 1'b0;
        if (wb0_valid_i && !flush_q) begin
          ready_q[wb0_tag_i] <= 1'b1;
          res_q[wb0_tag_i]   <= wb0_res_i;
        end
        if (wb1_valid_i && !flush_q) begin
          ready_q[wb1_tag_i] <= 1'b1;
          res_q[wb1_tag_i]   <= wb1_res_i;
        end
      end
      c0_valid_q <= c0_s;
      c0_rd_q    <= c0_s ? rd_q[head_q]  : 5'd0;
      c0_res_q   <= c0_s ? res_q[head_q] : 32'd0;
      c0_tag_q   <= c0_s ? head_q        : {TAG_W{1'b0}};
      c1_valid_q <= c1_s;
      c1_rd_q    <= c1_s ? rd_q[h1_s]    : 5'd0;
      c1_res_q   <= c1_s ? res_q[h1_s]   : 32'd0;
      c1_tag_q   <= c1_s ? h1_s          : {TAG_W{1'b0}};
      flush_q    <= mispred_s;
      flush_pc_q <= mispred_s ? flush_pc_s : 32'd0;
      bp_valid_q <= br_s;
      bp_pc_q    <= br_s ? pc_q[br_tag_s] : 32'd0;
      bp_taken_q <= br_s && taken_q[br_tag_s];
    end
  end

  // Entry payload; never read unless the entry is live, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (rdy_i && !rst_i) begin
      if (disp_acc_s && !mispred_s) begin
        pc_q[tail_q]    <= disp_pc_i;
        rd_q[tail_q]    <= disp_rd_i;
        is_br_q[tail_q] <= disp_is_br_i;
        pred_q[tail_q]  <= disp_pred_taken_i;
        is_st_q[tail_q] <= disp_is_store_i;
        taken_q[tail_q] <= 1'b0;
      end
      if (wb1_valid_i && !flush_q && !mispred_s) begin
        taken_q[wb1_tag_i]  <= wb1_taken_i;
        target_q[wb1_tag_i] <= wb1_target_i;
      end
    end
  end

  // Operand lookup; wb1 beats wb0 beats stored data when forwarding is enabled.
  always_comb begin
`ifdef ROB_WB_BYPASS_EN
    if (wb1_valid_i && (wb1_tag_i == q0_tag_i)) begin
      q0_ready_o = 1'b1;  q0_value_o = wb1_res_i;
    end else if (wb0_valid_i && (wb0_tag_i == q0_tag_i)) begin
      q0_ready_o = 1'b1;  q0_value_o = wb0_res_i;
    end else begin
      q0_ready_o = ready_q[q0_tag_i];  q0_value_o = res_q[q0_tag_i];
    end
    if (wb1_valid_i && (wb1_tag_i == q1_tag_i)) begin
      q1_ready_o = 1'b1;  q1_value_o = wb1_res_i;
    end else if (wb0_valid_i && (wb0_tag_i == q1_tag_i)) begin
      q1_ready_o = 1'b1;  q1_value_o = wb0_res_i;
    end else begin
      q1_ready_o = ready_q[q1_tag_i];  q1_value_o = res_q[q1_tag_i];
    end
`else
    q0_ready_o = ready_q[q0_tag_i];
    q0_value_o = res_q[q0_tag_i];
    q1_ready_o = ready_q[q1_tag_i];
    q1_value_o = res_q[q1_tag_i];
`endif
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Directed bench for rob_multi_commit (DEPTH=16, COMMIT_W=2) with a commit scoreboard.
module tb_rob_multi_commit;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        disp_valid, disp_is_br, disp_pred_taken, disp_is_store;
  logic [31:0] disp_pc;
  logic [4:0]  disp_rd;
  logic [3:0]  disp_tag;
  logic        rob_full;
  logic        wb0_valid, wb1_valid, wb1_taken;
  logic [3:0]  wb0_tag, wb1_tag, q0_tag, q1_tag, head_tag, commit0_tag, commit1_tag;
  logic [31:0] wb0_res, wb1_res, wb1_target, q0_value, q1_value;
  logic        q0_ready, q1_ready, head_is_store;
  logic        commit0_valid, commit1_valid, flush, bp_upd_valid, bp_upd_taken;
  logic [4:0]  commit0_rd, commit1_rd;
  logic [31:0] commit0_res, commit1_res, flush_pc, bp_upd_pc;

  typedef struct { logic [4:0] rd; logic [31:0] res; logic [3:0] tag; } exp_t;
  exp_t sb_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  rob_multi_commit #(.DEPTH(16), .COMMIT_W(2)) dut (
    .clk_i(clk), .rst_i(rst), .rdy_i(rdy),
    .disp_valid_i(disp_valid), .disp_pc_i(disp_pc), .disp_rd_i(disp_rd),
    .disp_is_br_i(disp_is_br), .disp_pred_taken_i(disp_pred_taken), .disp_is_store_i(disp_is_store),
    .disp_tag_o(disp_tag), .rob_full_o(rob_full),
    .wb0_valid_i(wb0_valid), .wb0_tag_i(wb0_tag), .wb0_res_i(wb0_res),
    .wb1_valid_i(wb1_valid), .wb1_tag_i(wb1_tag), .wb1_res_i(wb1_res),
    .wb1_taken_i(wb1_taken), .wb1_target_i(wb1_target),
    .q0_tag_i(q0_tag), .q1_tag_i(q1_tag), .q0_ready_o(q0_ready), .q1_ready_o(q1_ready),
    .q0_value_o(q0_value), .q1_value_o(q1_value),
    .head_tag_o(head_tag), .head_is_store_o(head_is_store),
    .commit0_valid_o(commit0_valid), .commit0_rd_o(commit0_rd), .commit0_res_o(commit0_res),
    .commit0_tag_o(commit0_tag),
    .commit1_valid_o(commit1_valid), .commit1_rd_o(commit1_rd), .commit1_res_o(commit1_res),
    .commit1_tag_o(commit1_tag),
    .flush_o(flush), .flush_pc_o(flush_pc),
    .bp_upd_valid_o(bp_upd_valid), .bp_upd_pc_o(bp_upd_pc), .bp_upd_taken_o(bp_upd_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string slot, input logic [4:0] rd, input logic [31:0] res,
                         input logic [3:0] tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({slot, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({slot, "_rd"}, 32'(rd), 32'(e.rd));
      chk({slot, "_res"}, res, e.res);
      chk({slot, "_tag"}, 32'(tag), 32'(e.tag));
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] res, input logic [3:0] tag);
    exp_t e;
    e.rd = rd; e.res = res; e.tag = tag;
    sb_q.push_back(e);
  endtask

  // One clock; the commit monitor pops the scoreboard only for edges where rdy was high.
  task automatic step();
    logic was_rdy;
    was_rdy = rdy;
    @(posedge clk); #1;
    if (was_rdy && !rst) begin
      if (commit0_valid) pop_cmp("c0", commit0_rd, commit0_res, commit0_tag);
      if (commit1_valid) pop_cmp("c1", commit1_rd, commit1_res, commit1_tag);
    end
  endtask

  task automatic idle();
    disp_valid = 1'b0; wb0_valid = 1'b0; wb1_valid = 1'b0;
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic [4:0] rd, input logic br,
                          input logic pred, input logic st);
    disp_valid = 1'b1; disp_pc = pc; disp_rd = rd;
    disp_is_br = br; disp_pred_taken = pred; disp_is_store = st;
    step();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); step(); step(); rst = 1'b0;
    sb_q.delete();
  endtask

  initial begin
    rdy = 1'b1; rst = 1'b1;
    disp_valid = 1'b0; disp_pc = 32'd0; disp_rd = 5'd0;
    disp_is_br = 1'b0; disp_pred_taken = 1'b0; disp_is_store = 1'b0;
    wb0_valid = 1'b0; wb0_tag = 4'd0; wb0_res = 32'd0;
    wb1_valid = 1'b0; wb1_tag = 4'd0; wb1_res = 32'd0; wb1_taken = 1'b0; wb1_target = 32'd0;
    q0_tag = 4'd0; q1_tag = 4'd0;
    do_reset();

    // Reset state
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_disp_tag", 32'(disp_tag), 32'd0);
    chk("rst_head_tag", 32'(head_tag), 32'd0);
    chk("rst_c0_valid", 32'(commit0_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_bp_valid", 32'(bp_upd_valid), 32'd0);
    chk("rst_q0_ready", 32'(q0_ready), 32'd0);
    chk("rst_q0_value", q0_value, 32'd0);

    // Fill to full; entry 0 is a store
    dispatch(32'h1000, 5'd1, 1'b0, 1'b0, 1'b1);
    chk("fill_tag0", 32'(disp_tag), 32'd1);
    chk("head_is_store", 32'(head_is_store), 32'd1);
    for (int i = 1; i < 16; i++) begin
      logic [3:0] et;
      dispatch(32'h1000 + 32'(i * 4), 5'd1, 1'b0, 1'b0, 1'b0);
      et = 4'(i + 1);
      chk("fill_tag", 32'(disp_tag), 32'(et));
    end
    chk("full_after_16", 32'(rob_full), 32'd1);
    dispatch(32'h2000, 5'd2, 1'b0, 1'b0, 1'b0);
    chk("full_17th_tag", 32'(disp_tag), 32'd0);
    chk("full_17th_full", 32'(rob_full), 32'd1);
    chk("full_17th_head", 32'(head_tag), 32'd0);
    do_reset();

    // Two entries written back together commit together
    dispatch(32'h10, 5'd5, 1'b0, 1'b0, 1'b0);
    dispatch(32'h14, 5'd6, 1'b0, 1'b0, 1'b0);
    chk("pair_disp_tag", 32'(disp_tag), 32'd2);
    wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_res = 32'h11;
    wb1_valid = 1'b1; wb1_tag = 4'd1; wb1_res = 32'h22; wb1_taken = 1'b0;
    push(5'd5, 32'h11, 4'd0); push(5'd6, 32'h22, 4'd1);
    step(); idle();
    chk("pair_no_commit_yet", 32'(commit0_valid), 32'd0);
    q0_tag = 4'd0; #1;
    chk("pair_q0_ready", 32'(q0_ready), 32'd1);
    chk("pair_q0_value", q0_value, 32'h11);
    step();
    chk("pair_c0_valid", 32'(commit0_valid), 32'd1);
    chk("pair_c1_valid", 32'(commit1_valid), 32'd1);
    chk("pair_head", 32'(head_tag), 32'd2);
    step();
    chk("pair_pulse_drop", 32'(commit0_valid), 32'd0);

    // Out-of-order writeback, in-order commit
    dispatch(32'h18, 5'd7, 1'b0, 1'b0, 1'b0);
    dispatch(32'h1c, 5'd8, 1'b0, 1'b0, 1'b0);
    wb1_valid = 1'b1; wb1_tag = 4'd3; wb1_res = 32'h33; wb1_taken = 1'b0;
    step(); idle(); step();
    chk("ooo_wait", 32'(commit0_valid), 32'd0);
    wb0_valid = 1'b1; wb0_tag = 4'd2; wb0_res = 32'h44;
    push(5'd7, 32'h44, 4'd2); push(5'd8, 32'h33, 4'd3);
    step(); idle(); step();
    chk("ooo_c0", 32'(commit0_valid), 32'd1);
    chk("ooo_c1", 32'(commit1_valid), 32'd1);
    chk("ooo_head", 32'(head_tag), 32'd4);

    // Mispredicted taken branch in slot 0
    dispatch(32'h100, 5'd0, 1'b1, 1'b0, 1'b0);
    dispatch(32'h104, 5'd9, 1'b0, 1'b0, 1'b0);
    wb0_valid = 1'b1; wb0_tag = 4'd5; wb0_res = 32'h55;
    step(); idle();
    wb1_valid = 1'b1; wb1_tag = 4'd4; wb1_res = 32'd0; wb1_taken = 1'b1; wb1_target = 32'h200;
    push(5'd0, 32'd0, 4'd4);
    step(); idle(); step();
    chk("mp_c0", 32'(commit0_valid), 32'd1);
    chk("mp_c1", 32'(commit1_valid), 32'd0);
    chk("mp_bp_valid", 32'(bp_upd_valid), 32'd1);
    chk("mp_bp_pc", bp_upd_pc, 32'h100);
    chk("mp_bp_taken", 32'(bp_upd_taken), 32'd1);
    chk("mp_flush", 32'(flush), 32'd1);
    chk("mp_flush_pc", flush_pc, 32'h200);
    disp_valid = 1'b1; disp_pc = 32'h300; disp_rd = 5'd3; disp_is_br = 1'b0; disp_is_store = 1'b0;
    step(); idle();
    chk("mp_flush_drop", 32'(flush), 32'd0);
    chk("mp_head", 32'(head_tag), 32'd0);
    chk("mp_disp_ignored", 32'(disp_tag), 32'd0);
    chk("mp_young_c0", 32'(commit0_valid), 32'd0);
    chk("mp_bp_drop", 32'(bp_upd_valid), 32'd0);
    q0_tag = 4'd5; #1;
    chk("mp_young_cleared", 32'(q0_ready), 32'd0);

    // Predicted taken, actually not taken
    dispatch(32'h40, 5'd0, 1'b1, 1'b1, 1'b0);
    wb1_valid = 1'b1; wb1_tag = 4'd0; wb1_res = 32'd0; wb1_taken = 1'b0; wb1_target = 32'h80;
    push(5'd0, 32'd0, 4'd0);
    step(); idle(); step();
    chk("nt_flush", 32'(flush), 32'd1);
    chk("nt_flush_pc", flush_pc, 32'h44);
    chk("nt_bp_taken", 32'(bp_upd_taken), 32'd0);
    step();

    // Correctly predicted branch: training only
    dispatch(32'h60, 5'd0, 1'b1, 1'b1, 1'b0);
    dispatch(32'h64, 5'd10, 1'b0, 1'b0, 1'b0);
    wb0_valid = 1'b1; wb0_tag = 4'd1; wb0_res = 32'h66;
    wb1_valid = 1'b1; wb1_tag = 4'd0; wb1_res = 32'd0; wb1_taken = 1'b1; wb1_target = 32'h90;
    push(5'd0, 32'd0, 4'd0); push(5'd10, 32'h66, 4'd1);
    step(); idle(); step();
    chk("ok_c0", 32'(commit0_valid), 32'd1);
    chk("ok_c1_blocked", 32'(commit1_valid), 32'd0);
    chk("ok_bp_valid", 32'(bp_upd_valid), 32'd1);
    chk("ok_bp_pc", bp_upd_pc, 32'h60);
    chk("ok_no_flush", 32'(flush), 32'd0);
    step();
    chk("ok_alu_c0", 32'(commit0_valid), 32'd1);
    chk("ok_bp_drop", 32'(bp_upd_valid), 32'd0);

    // Mispredicted branch in slot 1
    dispatch(32'h7c, 5'd11, 1'b0, 1'b0, 1'b0);
    dispatch(32'h80, 5'd0, 1'b1, 1'b0, 1'b0);
    dispatch(32'h84, 5'd12, 1'b0, 1'b0, 1'b0);
    wb0_valid = 1'b1; wb0_tag = 4'd4; wb0_res = 32'h88;
    step(); idle();
    wb0_valid = 1'b1; wb0_tag = 4'd2; wb0_res = 32'h77;
    wb1_valid = 1'b1; wb1_tag = 4'd3; wb1_res = 32'd0; wb1_taken = 1'b1; wb1_target = 32'h300;
    push(5'd11, 32'h77, 4'd2); push(5'd0, 32'd0, 4'd3);
    step(); idle(); step();
    chk("s1_c0", 32'(commit0_valid), 32'd1);
    chk("s1_c1", 32'(commit1_valid), 32'd1);
    chk("s1_flush", 32'(flush), 32'd1);
    chk("s1_flush_pc", flush_pc, 32'h300);
    chk("s1_bp_pc", bp_upd_pc, 32'h80);
    step();
    chk("s1_young_c0", 32'(commit0_valid), 32'd0);
    chk("s1_head", 32'(head_tag), 32'd0);

    // Query forwarding, wb port collision, rdy freeze
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(32'h500 + 32'(i * 4), 5'(i + 1), 1'b0, 1'b0, 1'b0);
    q0_tag = 4'd3;
    wb1_valid = 1'b1; wb1_tag = 4'd3; wb1_res = 32'hABCD; wb1_taken = 1'b0;
    #1;
`ifdef ROB_WB_BYPASS_EN
    chk("byp_ready", 32'(q0_ready), 32'd1);
    chk("byp_value", q0_value, 32'hABCD);
`else
    chk("byp_ready", 32'(q0_ready), 32'd0);
    chk("byp_value", q0_value, 32'd0);
`endif
    step(); idle();
    chk("byp_next_ready", 32'(q0_ready), 32'd1);
    chk("byp_next_value", q0_value, 32'hABCD);
    wb0_valid = 1'b1; wb0_tag = 4'd0; wb0_res = 32'h1;
    wb1_valid = 1'b1; wb1_tag = 4'd0; wb1_res = 32'h2;
    push(5'd1, 32'h2, 4'd0);
    step(); idle();
    q0_tag = 4'd0; #1;
    chk("coll_value", q0_value, 32'h2);
    step();
    chk("coll_c0", 32'(commit0_valid), 32'd1);
    chk("coll_c1", 32'(commit1_valid), 32'd0);
    wb0_valid = 1'b1; wb0_tag = 4'd1; wb0_res = 32'h9;
    push(5'd2, 32'h9, 4'd1);
    step(); idle(); step();
    chk("frz_c0_before", 32'(commit0_valid), 32'd1);
    rdy = 1'b0; disp_valid = 1'b1; disp_pc = 32'h600; disp_rd = 5'd4;
    step();
    chk("frz_c0_held", 32'(commit0_valid), 32'd1);
    chk("frz_disp_tag", 32'(disp_tag), 32'd4);
    rdy = 1'b1; idle();
    step();
    chk("frz_c0_released", 32'(commit0_valid), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rob_multi_commit.md
# rob_multi_commit

Parametrised reorder buffer for the out-of-order RV32I core, successor to the single-commit ROB. It sits between the dispatcher, the ALU/LSB writeback buses, the register file and the branch predictor. Added over the previous generation: configurable depth, all `DEPTH` entries usable through count-based full/empty, two writeback ports, up to `COMMIT_W` in-order retirements per cycle, and a fall-through PC computed on flush.

## Interface
- `DEPTH`, 16: entry count; power of two, 4..64.
- `TAG_W`, `$clog2(DEPTH)`: width of tags and pointers.
- `COMMIT_W`, 2: commits per cycle; only 1 or 2 are legal.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, all state and outputs hold.
- `disp_valid` in 1; `disp_pc` in 32; `disp_rd` in 5; `disp_is_br` in 1; `disp_pred_taken` in 1; `disp_is_store` in 1: new entry.
- `disp_tag` out TAG_W: tag assigned to the current dispatch (= tail).
- `rob_full` out 1: high when count == DEPTH.
- `wb0_valid` in 1; `wb0_tag` in TAG_W; `wb0_res` in 32: LSB writeback.
- `wb1_valid` in 1; `wb1_tag` in TAG_W; `wb1_res` in 32; `wb1_taken` in 1; `wb1_target` in 32: ALU writeback.
- `q0_tag`/`q1_tag` in TAG_W; `q0_ready`/`q1_ready` out 1; `q0_value`/`q1_value` out 32: operand lookup.
- `head_tag` out TAG_W; `head_is_store` out 1: LSB store-release view of the oldest entry.
- `commit0_valid` out 1; `commit0_rd` out 5; `commit0_res` out 32; `commit0_tag` out TAG_W: slot 0.
- `commit1_valid`, `commit1_rd`, `commit1_res`, `commit1_tag`: slot 1; tied to 0 when COMMIT_W==1.
- `flush` out 1; `flush_pc` out 32: misprediction redirect.
- `bp_upd_valid` out 1; `bp_upd_pc` out 32; `bp_upd_taken` out 1: predictor training.

## Operation
- **Storage.** Circular buffer with `head`, `tail` (TAG_W bits, natural wrap) and `count` (TAG_W+1 bits).
  - Empty when count==0.
  - Full when count==DEPTH.
- **Dispatch.** Accepted when `disp_valid && !rob_full`; ignored when full.
  - Writes the entry at tail, clears its ready flag and advances tail.
- **Writeback.** Sets ready and stores `res`; wb1 also stores taken and target.
  - If wb0 and wb1 carry the same tag, wb1 wins.
  - Writeback to a non-live tag is a protocol error; it is ignored by the check model.
- **Commit slot 0.** Fires when the head entry is ready and count>0.
- **Commit slot 1.** Fires only when all of the following hold:
  - slot 0 fires;
  - entry head+1 is live and ready;
  - slot 0 is neither a branch nor a store;
  - entry head+1 is not a store.
  - A branch may occupy slot 1; a mispredicted branch in slot 1 is handled exactly as in slot 0.
- **Pointer arithmetic.** Each cycle, `count` changes by (+1 on dispatch) − (number of commits). Simultaneous dispatch and commit at full or empty are legal.
- **Branch commit.**
  - `bp_upd_*` pulses for one cycle.
  - When `taken != pred_taken`, the flush sequence runs:
    - `flush_pc` = target if taken, else pc+4;
    - `flush`=1;
    - any younger commit in the same cycle is suppressed.
- **Flush.** In the cycle `flush` is high, the ROB is cleared to its reset state and ignores dispatch and writeback; `flush` deasserts next cycle.
- **Query.** `qN_ready` and `qN_value` are combinational from the entry at `qN_tag`.
- **Head view.** `head_is_store` = live head entry is a store; the LSB releases the store when it matches `head_tag`.

## Timing
- **Reset.** Every output resets to 0; `rob_full`=0, `disp_tag`=0, `head_tag`=0.
- **Commit latency.** Writeback at edge N; commit outputs are registered and valid during cycle N+1.
- **Same-cycle writeback.** Writeback and commit in the same cycle: the entry commits one cycle later.
- **Pulse width.** Commit, bp_upd and flush outputs are one-cycle pulses; they drop to 0 on idle cycles.
- **Dispatch visibility.**
  - `disp_tag` and `rob_full` are combinational from registered state.
  - A dispatched entry is visible to queries the next cycle.
- **rdy low.** Everything freezes, including a pending `flush` pulse, which is extended until rdy returns.
- **rst.** Overrides everything, including mid-flush.

## Configuration
- `ROB_WB_BYPASS_EN` defined:
  - `qN_ready`/`qN_value` also match same-cycle `wb0`/`wb1` by tag, with wb1 having priority over wb0, which has priority over stored data.
  - Results reach the dispatcher one cycle earlier.
- Undefined: queries reflect stored state only.

## Test plan
- Reset, then dispatch 16 entries with DEPTH=16 and no writeback -> `rob_full`=1 after the 16th; a 17th dispatch is ignored; `disp_tag` stays 0 (wrapped).
- Dispatch tags 0,1 with rd=5,6; writeback both in one cycle (res 0x11, 0x22) -> next cycle commit0 (rd 5, 0x11) and commit1 (rd 6, 0x22) together; count returns to 0.
- Writeback tag 1 before tag 0 -> no commit until tag 0 is ready; then in-order commit 0 and 1 in the same cycle.
- Branch at pc 0x100, pred_taken=0, wb1 taken=1 target 0x200 -> commit0 valid; bp_upd pc 0x100 taken=1; `flush`=1 with `flush_pc`=0x200; next cycle count=0, `head_tag`=0; a younger ready entry does not commit.
- Branch pred_taken=1, actual not taken, pc 0x40 -> `flush_pc`=0x44; a correctly predicted branch gives bp_upd only, no flush.
- With `ROB_WB_BYPASS_EN`: q0_tag=3 while wb1 writes tag 3 value 0xABCD -> q0_ready=1, q0_value=0xABCD in the same cycle. Without it, both are 0 until the next cycle.
